fifo_pkt_framer: RTL and testbench

Packet framer that drains a first-word-fall-through FIFO and emits framed beats with `valid`/`ready`/`last` to a packet sink, such as a USB bulk IN endpoint. It sits directly downstream of the shallow register FIFO, driving that FIFO's read-enable from its empty flag and head data. A packet closes on one of three events: the packet reaches `MAX_LEN` beats, the FIFO has been idle for `TIMEOUT` cycles, or an explicit flush is requested. A one-word holding register supplies the look-ahead needed to mark the final beat.

---
 rtl/fifo_pkt_framer.sv | 119 +++++++++++
 tb/tb_fifo_pkt_framer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_framer.sv
// fifo_pkt_framer
// Drains a first-word-fall-through FIFO into a valid/ready/last packet stream.
// A one-word holding register gives the look-ahead needed to know whether the
// held word is the final beat. A packet closes when it reaches MAX_LEN beats,
// when the FIFO has been idle for TIMEOUT cycles, or after a flush request
// once the FIFO runs dry.
//
// Ports:
//   clk, rst_n   - clock (rising edge) and asynchronous active-low reset
//   fifo_data    - FIFO head word, valid while fifo_empty = 0
//   fifo_empty   - FIFO empty flag
//   fifo_re      - FIFO pop strobe, only ever asserted with fifo_empty = 0
//   flush        - single-cycle request to close the current packet
//   out_data     - beat data
//   out_valid    - beat available
//   out_last     - final beat of packet (meaningful only on a transfer)
//   out_ready    - sink accepts the beat
module fifo_pkt_framer #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 64,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_re,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready
);

  localparam int CW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LEN - 1);
  localparam logic [TW-1:0] TMR_MAX = TW'(TIMEOUT);

  logic [WIDTH-1:0] h_data;
  logic             h_valid;
  logic             run;
  logic [CW-1:0]    cnt;
  logic [TW-1:0]    timer;
  logic             to_flag;
  logic             fl_flag;

  logic xfer;
  logic at_max;
  logic close;
  logic idle;

  assign xfer   = out_valid & out_ready;
  assign at_max = (cnt == CNT_MAX);
  assign close  = at_max | to_flag | fl_flag;
  // Timer runs only while a word waits for a successor that is not arriving.
  assign idle   = h_valid & fifo_empty & ~to_flag;

  // Refill the holding register when it is empty or being emptied this cycle.
  assign fifo_re   = run & ~fifo_empty & (~h_valid | xfer);
  assign out_data  = h_data;
  // A held word is only offered once its last/not-last status is known:
  // either a successor is visible in the FIFO or the packet is closing.
  assign out_valid = h_valid & (~fifo_empty | close);
  assign out_last  = h_valid & (at_max | fifo_empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_data  <= '0;
      h_valid <= 1'b0;
      run     <= 1'b0;
      cnt     <= '0;
      timer   <= '0;
      to_flag <= 1'b0;
      fl_flag <= 1'b0;
    end else begin
      // Delays the first pop by one cycle after reset release.
      run <= 1'b1;

      if (fifo_re) begin
        h_data  <= fifo_data;
        h_valid <= 1'b1;
      end else if (xfer) begin
        h_valid <= 1'b0;
      end

      if (xfer) begin
        if (out_last) cnt <= '0;
        else          cnt <= cnt + 1'b1;
      end

      if (idle) begin
        if (timer == TMR_MAX) begin
          timer <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end else begin
        timer <= '0;
      end

      // Clearing wins: a transfer or fresh data makes the timeout moot.
      if (xfer | ~fifo_empty) begin
        to_flag <= 1'b0;
      end else if (idle && timer == TMR_MAX) begin
        to_flag <= 1'b1;
      end

      // A flush with nothing held and nothing queued has no packet to close.
      // Setting wins over clearing so a flush on the closing beat re-arms.
      if (flush && (h_valid || !fifo_empty)) begin
        fl_flag <= 1'b1;
      end else if (xfer && out_last) begin
        fl_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_pkt_framer.sv
// Testbench for fifo_pkt_framer: a queue-based FWFT FIFO feeds the DUT, every
// pushed word is recorded in a scoreboard with its expected last flag (or
// "don't care"), and an independent monitor checks each transferred beat.
module tb_fifo_pkt_framer;

  localparam int W  = 8;
  localparam int ML = 4;
  localparam int TO = 12;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] fifo_data;
  logic         fifo_empty;
  logic         fifo_re;
  logic         flush;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_last;
  logic         out_ready;

  fifo_pkt_framer #(.WIDTH(W), .MAX_LEN(ML), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_re    (fifo_re),
    .flush      (flush),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // last: 0 or 1 = required value, 2 = not predicted for this word
  typedef struct {
    logic [W-1:0] d;
    int           last;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] fifo_q[$];

  int total  = 0;
  int passed = 0;
  int cyc    = 0;
  int last_pop_cyc = 0;
  int re_viol = 0;
  bit re_s, ov_s, es_s;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // One clock cycle: sample outputs mid-cycle, then apply the FIFO pop that
  // the DUT requested and the next stimulus just after the rising edge.
  task automatic cycle(input bit pe, input logic [W-1:0] w, input int le,
                       input bit fl, input bit rd);
    @(negedge clk);
    cyc++;
    re_s = fifo_re;
    ov_s = out_valid;
    es_s = fifo_empty;
    if (re_s) last_pop_cyc = cyc;
    @(posedge clk);
    #1;
    if (re_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (pe) begin
      fifo_q.push_back(w);
      exp_q.push_back('{d: w, last: le});
    end
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? '0 : fifo_q[0];
    flush      = fl;
    out_ready  = rd;
  endtask

  // Idle until a beat is offered with the FIFO empty; latency from last pop.
  task automatic wait_close(output int lat);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      cycle(1'b0, '0, 0, 1'b0, 1'b1);
      if (ov_s && es_s) begin
        lat = cyc - last_pop_cyc;
        break;
      end
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n && exp_q.size() > 0; i++)
      cycle(1'b0, '0, 0, 1'b0, 1'b1);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic idle_quiet(input int n, input bit fl_first, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, '0, 0, fl_first && (i == 0), 1'b1);
      if (ov_s) seen++;
    end
  endtask

  // Monitor: checks every transferred beat against the scoreboard, packet
  // length against MAX_LEN, and output stability while stalled.
  initial begin : monitor
    exp_t         e;
    bit           prev_stall;
    logic [W-1:0] prev_data;
    int           beat_in_pkt;
    prev_stall  = 1'b0;
    prev_data   = '0;
    beat_in_pkt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall  = 1'b0;
        beat_in_pkt = 0;
      end else begin
        if (fifo_re && fifo_empty) re_viol++;
        if (prev_stall) begin
          chk("stall_valid", int'(out_valid), 1);
          chk("stall_data", int'(out_data), int'(prev_data));
        end
        if (out_valid && out_ready) begin
          $display("beat data=%02h last=%0d cycle=%0d", out_data, out_last, cyc);
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", int'(out_data), int'(e.d));
            if (e.last != 2) chk("beat_last", int'(out_last), e.last);
          end
          beat_in_pkt++;
          if (beat_in_pkt >= ML) chk("max_len_last", int'(out_last), 1);
          if (out_last) beat_in_pkt = 0;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  initial begin : stim
    int lat;
    int seen;
    int pushed;
    bit pe;
    bit fl;
    rst_n      = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = '0;
    flush      = 1'b0;
    out_ready  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_re", int'(fifo_re), 0);
    rst_n = 1'b1;
    repeat (2) cycle(1'b0, '0, 0, 1'b0, 1'b1);

    // Ten back-to-back words: packets of 4, 4, then 2 closed by timeout
    for (int k = 0; k < 10; k++)
      cycle(1'b1, W'(8'h30 + k), (k == 3 || k == 7 || k == 9) ? 1 : 0, 1'b0, 1'b1);
    wait_close(lat);
    chk("timeout_latency_10w", lat, TO + 2);
    drain(50);

    // Single word then idle
    cycle(1'b1, 8'hA5, 1, 1'b0, 1'b1);
    wait_close(lat);
    chk("timeout_latency_a5", lat, TO + 2);
    drain(50);

    // Flush closes as soon as the FIFO runs dry
    cycle(1'b1, 8'h01, 0, 1'b0, 1'b1);
    cycle(1'b1, 8'h02, 1, 1'b1, 1'b1);
    wait_close(lat);
    chk("flush_latency", lat, 1);
    repeat (3) cycle(1'b0, '0, 0, 1'b0, 1'b1);
    drain(50);

    // Random traffic with random backpressure
    pushed = 0;
    for (int i = 0; i < 3000 && pushed < 200; i++) begin
      pe = ($urandom_range(0, 99) < 70);
      fl = (pushed < 170) && ($urandom_range(0, 99) < 5);
      cycle(pe, W'($urandom), 2, fl, 1'($urandom_range(0, 1)));
      if (pe) pushed++;
    end
    drain(800);

    // Exactly MAX_LEN words, then idle; then a flush while idle and empty
    for (int k = 0; k < ML; k++)
      cycle(1'b1, W'(8'hC0 + k), (k == ML - 1) ? 1 : 0, 1'b0, 1'b1);
    drain(50);
    idle_quiet(3 * TO, 1'b0, seen);
    chk("no_zero_len_pkt", seen, 0);
    idle_quiet(3 * TO, 1'b1, seen);
    chk("idle_flush_noop", seen, 0);

    // Reset mid-packet with a word held
    cycle(1'b1, 8'h10, 2, 1'b0, 1'b1);
    cycle(1'b1, 8'h11, 2, 1'b0, 1'b1);
    cycle(1'b1, 8'h12, 0, 1'b0, 1'b0);
    cycle(1'b1, 8'h13, 0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_last", int'(out_last), 0);
    chk("midrst_data", int'(out_data), 0);
    chk("midrst_re", int'(fifo_re), 0);
    // The held word 0x11 is lost by the reset
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    cycle(1'b0, '0, 0, 1'b0, 1'b1);
    rst_n = 1'b1;
    #1;
    chk("release_no_pop", int'(fifo_re), 0);
    cycle(1'b1, 8'h14, 0, 1'b0, 1'b1);
    cycle(1'b1, 8'h15, 1, 1'b0, 1'b1);
    drain(50);

    chk("re_while_empty", re_viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
